// File: rtl/input_debouncer.sv
// input_debouncer: per-channel 2-flop synchroniser plus saturating stability counter.
// Optional macro DEBOUNCE_EDGE_EN adds registered key press/release pulses.
module input_debouncer #(
  parameter int NUM_SW          = 10,
  parameter int NUM_KEY         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic               CoreClock,
  input  logic               Reset,
  input  logic [NUM_SW-1:0]  w_SwitchesRaw,
  input  logic [NUM_KEY-1:0] w_KeysRaw,
  output logic [NUM_SW-1:0]  w_Switches,
  output logic [NUM_KEY-1:0] w_Keys
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [NUM_KEY-1:0] w_KeyPress,
  output logic [NUM_KEY-1:0] w_KeyRelease
`endif
);

  localparam int NCH = NUM_SW + NUM_KEY;
  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEY-1:0] KEY_IDLE =
    {NUM_KEY{KEY_ACTIVE_LOW}};

  logic [NUM_SW-1:0]  r_sw_s1;
  logic [NUM_SW-1:0]  r_sw_s2;
  logic [NUM_KEY-1:0] r_key_s1;
  logic [NUM_KEY-1:0] r_key_s2;

  logic [NUM_KEY-1:0] w_key_sync;
  logic [NCH-1:0]     w_sync;

  logic [NCH-1:0]     r_clean;
  logic [CNT_W-1:0]   r_cnt [NCH];

  logic [NCH-1:0]     w_match;
  logic [NCH-1:0]     w_term;
  logic [NCH-1:0]     w_fire;
  logic [NCH-1:0]     w_clean_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt [NCH];

  // Key sync flops clear to the released pin level, so the normalised
  // key value is 0 out of reset and short filters see no phantom press.
  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_key_s1 <= KEY_IDLE;
      r_key_s2 <= KEY_IDLE;
    end else begin
      r_sw_s1  <= w_SwitchesRaw;
      r_sw_s2  <= r_sw_s1;
      r_key_s1 <= w_KeysRaw;
      r_key_s2 <= r_key_s1;
    end
  end

  assign w_key_sync = KEY_ACTIVE_LOW ? ~r_key_s2 : r_key_s2;
  assign w_sync     = {w_key_sync, r_sw_s2};

  always_comb begin
    w_match     = '0;
    w_term      = '0;
    w_fire      = '0;
    w_clean_nxt = r_clean;
    for (int i = 0; i < NCH; i++) begin
      w_cnt_nxt[i] = '0;
    end
    for (int i = 0; i < NCH; i++) begin
      w_match[i] = (w_sync[i] == r_clean[i]);
      w_term[i]  = (r_cnt[i] == TERM);
      w_fire[i]  = !w_match[i] && w_term[i];
      if (w_fire[i]) begin
        w_clean_nxt[i] = w_sync[i];
      end
      if (!w_match[i] && !w_term[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      r_clean <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_clean <= w_clean_nxt;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign w_Switches = r_clean[NUM_SW-1:0];
  assign w_Keys     = r_clean[NCH-1:NUM_SW];

`ifdef DEBOUNCE_EDGE_EN
  logic [NUM_KEY-1:0] r_press;
  logic [NUM_KEY-1:0] r_release;
  logic [NUM_KEY-1:0] w_key_fire;

  assign w_key_fire = w_fire[NCH-1:NUM_SW];

  // Pulses register on the same edge the clean level flips.
  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= w_key_fire & w_key_sync;
      r_release <= w_key_fire & ~w_key_sync;
    end
  end

  assign w_KeyPress   = r_press;
  assign w_KeyRelease = r_release;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed vector table plus corner sequences.
// Runs with DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1; pulse checks need DEBOUNCE_EDGE_EN.
module tb_input_debouncer;

  logic       clk;
  logic       rst;
  logic [9:0] sw_raw;
  logic [3:0] key_raw;
  logic [9:0] sw;
  logic [3:0] key;
  logic [3:0] kp;
  logic [3:0] kr;

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  input_debouncer #(
    .NUM_SW(10),
    .NUM_KEY(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .CoreClock(clk),
    .Reset(rst),
    .w_SwitchesRaw(sw_raw),
    .w_KeysRaw(key_raw),
    .w_Switches(sw),
    .w_Keys(key)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .w_KeyPress(kp),
    .w_KeyRelease(kr)
`endif
  );

`ifndef DEBOUNCE_EDGE_EN
  assign kp = '0;
  assign kr = '0;
`endif

  typedef struct {
    string      name;
    logic       rst;
    logic [9:0] sw;
    logic [3:0] key;
    int         n;
    logic [9:0] esw;
    logic [3:0] ekey;
    logic [3:0] ekp;
    logic [3:0] ekr;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(
    input string nm, input logic r,
    input logic [9:0] s, input logic [3:0] k,
    input int n, input logic [9:0] es,
    input logic [3:0] ek, input logic [3:0] ep,
    input logic [3:0] er);
    vec_t v;
    v.name = nm; v.rst = r; v.sw = s; v.key = k;
    v.n = n; v.esw = es; v.ekey = ek;
    v.ekp = ep; v.ekr = er;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_pulse(input string nm,
                           input logic [3:0] ep,
                           input logic [3:0] er);
`ifdef DEBOUNCE_EDGE_EN
    chk({nm, "_press"}, 16'(kp), 16'(ep));
    chk({nm, "_release"}, 16'(kr), 16'(er));
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    sw_raw  = 10'h3FF;
    key_raw = 4'hF;

    tbl[0]  = mk("rst_a", 1, 10'h3FF, 4'hF, 1, 10'h000, 4'h0, 4'h0, 4'h0);
    tbl[1]  = mk("rst_b", 1, 10'h3FF, 4'hF, 1, 10'h000, 4'h0, 4'h0, 4'h0);
    tbl[2]  = mk("rst_c", 1, 10'h3FF, 4'hF, 1, 10'h000, 4'h0, 4'h0, 4'h0);
    tbl[3]  = mk("sw_pre", 0, 10'h3FF, 4'hF, 5, 10'h000, 4'h0, 4'h0, 4'h0);
    tbl[4]  = mk("sw_rise", 0, 10'h3FF, 4'hF, 1, 10'h3FF, 4'h0, 4'h0, 4'h0);
    tbl[5]  = mk("sw_hold", 0, 10'h3FF, 4'hF, 3, 10'h3FF, 4'h0, 4'h0, 4'h0);
    tbl[6]  = mk("k0_pre", 0, 10'h3FF, 4'hE, 5, 10'h3FF, 4'h0, 4'h0, 4'h0);
    tbl[7]  = mk("k0_press", 0, 10'h3FF, 4'hE, 1, 10'h3FF, 4'h1, 4'h1, 4'h0);
    tbl[8]  = mk("k0_held", 0, 10'h3FF, 4'hE, 1, 10'h3FF, 4'h1, 4'h0, 4'h0);
    tbl[9]  = mk("k0_relpre", 0, 10'h3FF, 4'hF, 5, 10'h3FF, 4'h1, 4'h0, 4'h0);
    tbl[10] = mk("k0_rel", 0, 10'h3FF, 4'hF, 1, 10'h3FF, 4'h0, 4'h0, 4'h1);
    tbl[11] = mk("k0_idle", 0, 10'h3FF, 4'hF, 1, 10'h3FF, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < 12; i++) begin
      rst     = tbl[i].rst;
      sw_raw  = tbl[i].sw;
      key_raw = tbl[i].key;
      step(tbl[i].n);
      chk({tbl[i].name, "_sw"}, 16'(sw), 16'(tbl[i].esw));
      chk({tbl[i].name, "_key"}, 16'(key), 16'(tbl[i].ekey));
      chk_pulse(tbl[i].name, tbl[i].ekp, tbl[i].ekr);
    end

    // Bounce on switch 3: drop it low first, then chatter.
    sw_raw = 10'h3F7;
    step(6);
    chk("b_low", 16'(sw), 16'h3F7);
    for (int p = 0; p < 4; p++) begin
      sw_raw[3] = (p % 2 == 0);
      for (int c = 0; c < 2; c++) begin
        step(1);
        chk("b_chatter", 16'(sw[3]), 16'h0);
      end
    end
    sw_raw[3] = 1'b1;
    step(5);
    chk("b_hold_pre", 16'(sw[3]), 16'h0);
    step(1);
    chk("b_hold_rise", 16'(sw), 16'h3FF);

    // Keys 1 and 2 together; key 2 lets go after 3 cycles.
    key_raw = 4'h9;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (c == 3) key_raw = 4'hD;
      chk("s_key2", 16'(key[2]), 16'h0);
      chk("s_key1", 16'(key[1]), 16'(c >= 6));
      chk_pulse("s_edge", (c == 6) ? 4'h2 : 4'h0, 4'h0);
    end
    key_raw = 4'hF;
    step(6);
    chk("s_clear", 16'(key), 16'h0);

    // Reset landing mid-count on switch 0.
    sw_raw = 10'h3FE;
    step(6);
    chk("r_low", 16'(sw), 16'h3FE);
    sw_raw = 10'h3FF;
    step(3);
    chk("r_counting", 16'(sw[0]), 16'h0);
    rst = 1'b1;
    step(1);
    chk("r_reset_sw", 16'(sw), 16'h000);
    chk("r_reset_key", 16'(key), 16'h0);
    chk_pulse("r_reset", 4'h0, 4'h0);
    rst = 1'b0;
    step(1);
    chk_pulse("r_first", 4'h0, 4'h0);
    step(4);
    chk("r_pre", 16'(sw), 16'h000);
    step(1);
    chk("r_rise", 16'(sw), 16'h3FF);
    chk("r_key", 16'(key), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
